// File: rtl/onehot_sequencer.sv
// Registered one-hot decoder with a ring sequencer: the active bit is loaded from a binary index
// or stepped up/down modulo N_OUT. Define ONEHOT_SEQ_AUTO_STEP_EN to add the run input and a DIV-cycle auto-step prescaler.
module onehot_sequencer #(
  parameter int IN_W  = 3,
  parameter int N_OUT = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [IN_W-1:0]  load_idx,
  input  logic             step,
  input  logic             dir,
`ifdef ONEHOT_SEQ_AUTO_STEP_EN
  input  logic             run,
`endif
  output logic [N_OUT-1:0] out,
  output logic [IN_W-1:0]  idx,
  output logic             wrap,
  output logic             err
);

  localparam logic [IN_W-1:0] LAST    = IN_W'(N_OUT - 1);
  localparam logic [IN_W:0]   N_OUT_X = (IN_W + 1)'(N_OUT);

  if ((N_OUT < 2) || (N_OUT > (2 ** IN_W)) || (DIV < 1)) begin : g_bad_cfg
    $error("onehot_sequencer: N_OUT must be 2..2**IN_W and DIV >= 1");
  end

  logic            step_any;
  logic [IN_W-1:0] nxt_idx;
  logic            nxt_wrap;
  logic            nxt_err;

`ifdef ONEHOT_SEQ_AUTO_STEP_EN
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             auto_tick;

  assign auto_tick = run && (cnt == CNT_LAST);
  assign step_any  = step || auto_tick;

  // Any load, legal or not, restarts the prescaler phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= auto_tick ? '0 : cnt + 1'b1;
    end
  end
`else
  assign step_any = step;
`endif

  always_comb begin
    nxt_idx  = idx;
    nxt_wrap = 1'b0;
    nxt_err  = 1'b0;
    if (load) begin
      if ({1'b0, load_idx} < N_OUT_X) begin
        nxt_idx = load_idx;
      end else begin
        nxt_err = 1'b1;
      end
    end else if (step_any) begin
      if (!dir) begin
        if (idx == LAST) begin
          nxt_idx  = '0;
          nxt_wrap = 1'b1;
        end else begin
          nxt_idx = idx + 1'b1;
        end
      end else begin
        if (idx == '0) begin
          nxt_idx  = LAST;
          nxt_wrap = 1'b1;
        end else begin
          nxt_idx = idx - 1'b1;
        end
      end
    end
  end

  // out is derived from the same next index so it can never disagree with idx.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx  <= '0;
      out  <= N_OUT'(1);
      wrap <= 1'b0;
      err  <= 1'b0;
    end else begin
      idx  <= nxt_idx;
      out  <= N_OUT'(1) << nxt_idx;
      wrap <= nxt_wrap;
      err  <= nxt_err;
    end
  end

endmodule

// File: tb/tb_onehot_sequencer.sv
// Bench for onehot_sequencer: an N_OUT=8 and an N_OUT=5 instance share stimulus and are
// compared against a position-integer model with modulo arithmetic.
module tb_onehot_sequencer;

  logic       clk = 1'b0;
  logic       rst, load, step, dir, run;
  logic [2:0] load_idx;
  logic [7:0] out8;
  logic [4:0] out5;
  logic [2:0] idx8, idx5;
  logic       wrap8, err8, wrap5, err5;

  int total = 0;
  int bad   = 0;

`ifdef ONEHOT_SEQ_AUTO_STEP_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam int DIV = 4;

  int nn[2] = '{8, 5};
  int pos[2];
  bit mw[2];
  bit me[2];
  int mcnt;

  always #5 clk = ~clk;

  onehot_sequencer #(.IN_W(3), .N_OUT(8), .DIV(DIV)) dut8 (
    .clk(clk), .rst(rst), .load(load), .load_idx(load_idx), .step(step), .dir(dir),
`ifdef ONEHOT_SEQ_AUTO_STEP_EN
    .run(run),
`endif
    .out(out8), .idx(idx8), .wrap(wrap8), .err(err8));

  onehot_sequencer #(.IN_W(3), .N_OUT(5), .DIV(DIV)) dut5 (
    .clk(clk), .rst(rst), .load(load), .load_idx(load_idx), .step(step), .dir(dir),
`ifdef ONEHOT_SEQ_AUTO_STEP_EN
    .run(run),
`endif
    .out(out5), .idx(idx5), .wrap(wrap5), .err(err5));

  // Apply one cycle of inputs, advance the model on the edge, sample 1 time unit later.
  task automatic drive(input bit r, input bit l, input int li, input bit s, input bit d, input bit ru);
    bit tick;
    rst = r; load = l; load_idx = 3'(li); step = s; dir = d; run = ru;
    @(posedge clk);
    tick = AUTO && ru && (mcnt == DIV - 1);
    for (int k = 0; k < 2; k++) begin
      mw[k] = 0;
      me[k] = 0;
      if (r) pos[k] = 0;
      else if (l) begin
        if (li < nn[k]) pos[k] = li;
        else me[k] = 1;
      end else if (s || tick) begin
        if (!d) begin
          mw[k] = (pos[k] == nn[k] - 1);
          pos[k] = (pos[k] + 1) % nn[k];
        end else begin
          mw[k] = (pos[k] == 0);
          pos[k] = (pos[k] + nn[k] - 1) % nn[k];
        end
      end
    end
    if (r || l) mcnt = 0;
    else if (AUTO && ru) mcnt = tick ? 0 : mcnt + 1;
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 5, 0, 0, 0);
    drive(1, 1, 5, 1, 0, 1);
    total++; if (out8 !== 8'b0000_0001) begin bad++; $display("FAIL reset_out got=%b exp=%b", out8, 8'b1); end
    total++; if (idx8 !== 3'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", idx8); end
    total++; if ({wrap8, err8, wrap5, err5} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {wrap8, err8, wrap5, err5}); end
    drive(0, 0, 0, 0, 0, 0);
    total++; if (out8 !== 8'b0000_0001 || out5 !== 5'b00001) begin bad++; $display("FAIL reset_hold got=%b/%b exp=1/1", out8, out5); end
  endtask

  task automatic test_load_sweep();
    for (int k = 0; k < 8; k++) begin
      drive(0, 1, k, 0, 0, 0);
      total++; if (out8 !== (8'd1 << k) || idx8 !== 3'(k)) begin bad++; $display("FAIL load8_%0d got=%b/%0d exp=%b/%0d", k, out8, idx8, 8'd1 << k, k); end
      total++; if (err8 !== 1'b0) begin bad++; $display("FAIL load8_err_%0d got=%b exp=0", k, err8); end
      total++; if (err5 !== (k >= 5)) begin bad++; $display("FAIL load5_err_%0d got=%b exp=%b", k, err5, k >= 5); end
    end
  endtask

  task automatic test_up_wrap();
    int exp_idx[3] = '{7, 0, 1};
    bit exp_w[3] = '{0, 1, 0};
    drive(0, 1, 6, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 1, 0, 0);
      total++; if (idx8 !== 3'(exp_idx[k]) || out8 !== (8'd1 << exp_idx[k])) begin bad++; $display("FAIL upwrap_idx_%0d got=%0d exp=%0d", k, idx8, exp_idx[k]); end
      total++; if (wrap8 !== exp_w[k]) begin bad++; $display("FAIL upwrap_pulse_%0d got=%b exp=%b", k, wrap8, exp_w[k]); end
    end
  endtask

  task automatic test_down_wrap();
    drive(0, 1, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 0);
    total++; if (idx5 !== 3'd0 || out5 !== 5'b00001 || wrap5 !== 1'b0) begin bad++; $display("FAIL down5_first got=%0d/%b/%b exp=0/00001/0", idx5, out5, wrap5); end
    drive(0, 0, 0, 1, 1, 0);
    total++; if (idx5 !== 3'd4 || out5 !== 5'b10000) begin bad++; $display("FAIL down5_wrap got=%0d/%b exp=4/10000", idx5, out5); end
    total++; if (wrap5 !== 1'b1) begin bad++; $display("FAIL down5_pulse got=%b exp=1", wrap5); end
  endtask

  task automatic test_illegal_priority();
    drive(0, 1, 6, 1, 0, 0);
    total++; if (err5 !== 1'b1 || out5 !== 5'b10000 || idx5 !== 3'd4) begin bad++; $display("FAIL illegal5 got=%b/%b/%0d exp=1/10000/4", err5, out5, idx5); end
    drive(0, 1, 2, 1, 0, 0);
    total++; if (idx5 !== 3'd2 || out5 !== 5'b00100 || err5 !== 1'b0 || wrap5 !== 1'b0) begin bad++; $display("FAIL loadstep5 got=%0d/%b/%b exp=2/00100/0", idx5, out5, err5); end
    drive(0, 0, 0, 0, 0, 0);
    total++; if (err5 !== 1'b0 || idx5 !== 3'd2) begin bad++; $display("FAIL idle5 got=%b/%0d exp=0/2", err5, idx5); end
  endtask

  task automatic check_all(input string tag, input int n);
    total++; if (idx8 !== 3'(pos[0]) || out8 !== (8'd1 << pos[0])) begin bad++; $display("FAIL %s8_%0d got=%0d/%b exp=%0d", tag, n, idx8, out8, pos[0]); end
    total++; if (wrap8 !== mw[0] || err8 !== me[0]) begin bad++; $display("FAIL %s8_flags_%0d got=%b%b exp=%b%b", tag, n, wrap8, err8, mw[0], me[0]); end
    total++; if (idx5 !== 3'(pos[1]) || out5 !== (5'd1 << pos[1])) begin bad++; $display("FAIL %s5_%0d got=%0d/%b exp=%0d", tag, n, idx5, out5, pos[1]); end
    total++; if (wrap5 !== mw[1] || err5 !== me[1]) begin bad++; $display("FAIL %s5_flags_%0d got=%b%b exp=%b%b", tag, n, wrap5, err5, mw[1], me[1]); end
  endtask

  task automatic test_auto_step();
    drive(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 9; n++) begin
      drive(0, 0, 0, 0, 0, 1);
      check_all("auto_run", n);
    end
    for (int n = 0; n < 3; n++) begin
      drive(0, 0, 0, 0, 0, 0);
      check_all("auto_hold", n);
    end
    drive(0, 1, 3, 0, 0, 1);
    for (int n = 0; n < 6; n++) begin
      drive(0, 0, 0, n == 1, 1, 1);
      check_all("auto_phase", n);
    end
  endtask

  task automatic test_random();
    drive(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 31) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0);
      check_all("rand", n);
    end
  endtask

  initial begin
    rst = 1; load = 0; load_idx = '0; step = 0; dir = 0; run = 0;
    mcnt = 0;
    for (int k = 0; k < 2; k++) begin pos[k] = 0; mw[k] = 0; me[k] = 0; end
    test_reset();
    test_load_sweep();
    test_up_wrap();
    test_down_wrap();
    test_illegal_priority();
    if (AUTO) test_auto_step();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
